// File: rtl/hdc_sched_pkg.sv
// rtl/hdc_sched_pkg.sv - shared scheduler types, perf counter width and default sizing
package hdc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } fold_sched_state_t;

    localparam int PERF_CNT_WIDTH = 16;

    // Default channel geometry used when the integrator does not override it
    localparam int TOTAL_NUM_CHANNEL     = 4;
    localparam int MAX_NUM_CHANNEL_WIDTH = 2;

    function automatic int ceil_log2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // A clear and an increment in the same cycle restart the count at one
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/fold_scheduler.sv
// rtl/fold_scheduler.sv - fold/channel beat sequencer; FOLD_SCHED_PERF_EN adds cycle/stall counters
module fold_scheduler
    import hdc_sched_pkg::*;
#(
    parameter int NUM_FOLDS       = 8,
    parameter int NUM_FOLDS_WIDTH = ceil_log2(8),
    parameter int NUM_CHANNEL     = TOTAL_NUM_CHANNEL,
    parameter int CHAN_WIDTH      = MAX_NUM_CHANNEL_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    output logic                       beat_valid,
    input  logic                       beat_ready,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
    output logic [CHAN_WIDTH-1:0]      chan_idx,
    output logic                       first_chan,
    output logic                       last_chan,
    input  logic                       fold_ack,
    output logic                       done,
    output logic                       busy
`ifdef FOLD_SCHED_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]  cycle_count,
    output logic [PERF_CNT_WIDTH-1:0]  stall_count
`endif
);

    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
    localparam logic [CHAN_WIDTH-1:0]      LAST_CHAN = CHAN_WIDTH'(NUM_CHANNEL - 1);
    localparam logic [NUM_FOLDS_WIDTH-1:0] FOLD_ONE  = {{(NUM_FOLDS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CHAN_WIDTH-1:0]      CHAN_ONE  = {{(CHAN_WIDTH-1){1'b0}}, 1'b1};

    fold_sched_state_t              state;
    logic [NUM_FOLDS_WIDTH-1:0]     fold_cnt;
    logic [CHAN_WIDTH-1:0]          chan_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fold_cnt <= '0;
            chan_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        state    <= ST_RUN;
                        fold_cnt <= '0;
                        chan_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (beat_ready) begin
                        if (chan_cnt == LAST_CHAN) begin
                            state <= ST_WAIT_ACK;
                        end else begin
                            chan_cnt <= chan_cnt + CHAN_ONE;
                        end
                    end
                end
                // fold_ack only matters here; acks seen in RUN are dropped
                ST_WAIT_ACK: begin
                    if (fold_ack) begin
                        if (fold_cnt == LAST_FOLD) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_RUN;
                            fold_cnt <= fold_cnt + FOLD_ONE;
                            chan_cnt <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    fold_cnt <= '0;
                    chan_cnt <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    fold_cnt <= '0;
                    chan_cnt <= '0;
                end
            endcase
        end
    end

    // Moore decode: every output depends only on registered state
    assign start_ready = (state == ST_IDLE);
    assign beat_valid  = (state == ST_RUN);
    assign done        = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign fold_idx    = fold_cnt;
    assign chan_idx    = chan_cnt;
    assign first_chan  = beat_valid && (chan_cnt == '0);
    assign last_chan   = beat_valid && (chan_cnt == LAST_CHAN);

`ifdef FOLD_SCHED_PERF_EN
    logic start_accept;
    assign start_accept = (state == ST_IDLE) && start_valid;

    // The accepting cycle counts as the first cycle of the sample
    sat_counter #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start_accept),
        .inc   (busy || start_accept),
        .count (cycle_count)
    );

    sat_counter #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start_accept),
        .inc   (beat_valid && !beat_ready),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fold_scheduler.sv
// tb/tb_fold_scheduler.sv - directed and randomized checks of fold_scheduler against a cycle-schedule model
module tb_fold_scheduler;

    localparam int NC   = 4;
    localparam int NF_A = 8;
    localparam int NF_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_valid = 1'b0;
    logic beat_ready  = 1'b0;
    logic fold_ack    = 1'b0;

    logic       a_start_ready, a_beat_valid, a_first, a_last, a_done, a_busy;
    logic [2:0] a_fold;
    logic [1:0] a_chan;
    logic       b_start_ready, b_beat_valid, b_first, b_last, b_done, b_busy;
    logic [0:0] b_fold;
    logic [1:0] b_chan;
`ifdef FOLD_SCHED_PERF_EN
    logic [15:0] a_cyc, a_stl, b_cyc, b_stl;
`endif

    always #5 clk = ~clk;

    fold_scheduler #(
        .NUM_FOLDS(NF_A), .NUM_FOLDS_WIDTH(3), .NUM_CHANNEL(NC), .CHAN_WIDTH(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(a_start_ready),
        .beat_valid(a_beat_valid), .beat_ready(beat_ready), .fold_idx(a_fold), .chan_idx(a_chan),
        .first_chan(a_first), .last_chan(a_last), .fold_ack(fold_ack), .done(a_done), .busy(a_busy)
`ifdef FOLD_SCHED_PERF_EN
        , .cycle_count(a_cyc), .stall_count(a_stl)
`endif
    );

    fold_scheduler #(
        .NUM_FOLDS(NF_B), .NUM_FOLDS_WIDTH(1), .NUM_CHANNEL(NC), .CHAN_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(b_start_ready),
        .beat_valid(b_beat_valid), .beat_ready(beat_ready), .fold_idx(b_fold), .chan_idx(b_chan),
        .first_chan(b_first), .last_chan(b_last), .fold_ack(fold_ack), .done(b_done), .busy(b_busy)
`ifdef FOLD_SCHED_PERF_EN
        , .cycle_count(b_cyc), .stall_count(b_stl)
`endif
    );

    typedef struct {
        bit start, ready, ack;
        bit valid, done, busy, chk_idx;
        int fold, chan;
    } step_t;

    step_t sched[$];
    int    exp_stalls;
    int    exp_cycles;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic step_t mk(bit start, bit ready, bit ack, bit valid, bit dn, bit busy,
                                 bit chk_idx, int fold, int chan);
        step_t s;
        s.start = start; s.ready = ready; s.ack = ack;
        s.valid = valid; s.done = dn; s.busy = busy; s.chk_idx = chk_idx;
        s.fold = fold; s.chan = chan;
        return s;
    endfunction

    // Expand one sample into its expected cycle-by-cycle schedule
    function automatic void add_sample(int nf, int sf, int sc, int sn, bit rand_stall,
                                       int ack_delay, bit hold_start);
        int ns, d;
        sched.push_back(mk(1'b1, rbit(), rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        exp_cycles = 1;
        exp_stalls = 0;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < NC; c++) begin
                ns = (f == sf && c == sc) ? sn : (rand_stall ? $urandom_range(0, 2) : 0);
                for (int k = 0; k < ns; k++) begin
                    sched.push_back(mk(hold_start | rbit(), 1'b0, rbit(), 1'b1, 1'b0, 1'b1, 1'b1, f, c));
                    exp_stalls++;
                    exp_cycles++;
                end
                sched.push_back(mk(hold_start | rbit(), 1'b1, rbit(), 1'b1, 1'b0, 1'b1, 1'b1, f, c));
                exp_cycles++;
            end
            d = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
            for (int k = 0; k < d; k++) begin
                sched.push_back(mk(hold_start | rbit(), rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f, 0));
                exp_cycles++;
            end
            sched.push_back(mk(hold_start | rbit(), rbit(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, f, 0));
            exp_cycles++;
        end
        sched.push_back(mk(hold_start, rbit(), rbit(), 1'b0, 1'b1, 1'b1, 1'b0, 0, 0));
        exp_cycles++;
    endfunction

    function automatic void add_idle(int n);
        for (int k = 0; k < n; k++)
            sched.push_back(mk(1'b0, rbit(), rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
    endfunction

    task automatic observe(input bit sel, output logic [31:0] ctl, output logic [31:0] idx);
        if (sel) begin
            ctl = 32'({b_beat_valid, b_done, b_busy, b_start_ready, b_first, b_last});
            idx = (32'(b_fold) << 8) | 32'(b_chan);
        end else begin
            ctl = 32'({a_beat_valid, a_done, a_busy, a_start_ready, a_first, a_last});
            idx = (32'(a_fold) << 8) | 32'(a_chan);
        end
    endtask

    task automatic run_sched(input bit sel, input int stop_at, input string name, output int done_at);
        logic [31:0] ctl, idx;
        logic [31:0] e_ctl;
        int acc_at;
        int n;
        acc_at  = -1;
        done_at = -1;
        n = (stop_at >= 0) ? stop_at + 1 : sched.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            observe(sel, ctl, idx);
            e_ctl = 32'({sched[i].valid, sched[i].done, sched[i].busy, !sched[i].busy,
                         sched[i].valid && sched[i].chan == 0,
                         sched[i].valid && sched[i].chan == NC - 1});
            check($sformatf("%s_ctl@%0d", name, i), ctl, e_ctl);
            if (sched[i].chk_idx)
                check($sformatf("%s_idx@%0d", name, i), idx, 32'((sched[i].fold << 8) | sched[i].chan));
            if (ctl[4] === 1'b1 && done_at < 0 && acc_at >= 0) done_at = i - acc_at;
            if (i == stop_at) break;
            if (sched[i].start && !sched[i].busy && acc_at < 0) acc_at = i;
            start_valid = sched[i].start;
            beat_ready  = sched[i].ready;
            fold_ack    = sched[i].ack;
        end
        sched.delete();
    endtask

    task automatic check_perf(input bit sel, input string name);
`ifdef FOLD_SCHED_PERF_EN
        check({name, "_cycle_count"}, 32'(sel ? b_cyc : a_cyc), 32'(exp_cycles));
        check({name, "_stall_count"}, 32'(sel ? b_stl : a_stl), 32'(exp_stalls));
`else
        if (sel && name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int dat;

    initial begin
        logic [31:0] ctl, idx;

        // reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        observe(1'b0, ctl, idx);
        check("reset_ctl_a", ctl, 32'b000100);
        check("reset_idx_a", idx, 32'd0);
        observe(1'b1, ctl, idx);
        check("reset_ctl_b", ctl, 32'b000100);
        rst = 1'b1;

        // full-rate sample
        add_sample(NF_A, -1, -1, 0, 1'b0, 0, 1'b0);
        add_idle(2);
        run_sched(1'b0, -1, "fullrate", dat);
        check("fullrate_done_lat", 32'(dat), 32'd41);
        check_perf(1'b0, "fullrate");

        // three-cycle stall at fold 2, chan 1
        do_reset();
        add_sample(NF_A, 2, 1, 3, 1'b0, 0, 1'b0);
        add_idle(2);
        run_sched(1'b0, -1, "stall", dat);
        check("stall_done_lat", 32'(dat), 32'd44);
        check_perf(1'b0, "stall");

        // fold_ack delayed five cycles every fold
        do_reset();
        add_sample(NF_A, -1, -1, 0, 1'b0, 5, 1'b0);
        add_idle(2);
        run_sched(1'b0, -1, "ackdly", dat);
        check("ackdly_done_lat", 32'(dat), 32'd81);
        check_perf(1'b0, "ackdly");

        // reset at fold 5, chan 2
        do_reset();
        add_sample(NF_A, -1, -1, 0, 1'b0, 0, 1'b0);
        run_sched(1'b0, 1 + 5 * (NC + 1) + 2, "prereset", dat);
        rst = 1'b0; start_valid = 1'b0; beat_ready = 1'b1; fold_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        observe(1'b0, ctl, idx);
        check("midreset_ctl", ctl, 32'b000100);
        check("midreset_idx", idx, 32'd0);
        add_idle(3);
        add_sample(NF_A, -1, -1, 0, 1'b1, -1, 1'b0);
        add_idle(1);
        run_sched(1'b0, -1, "postreset", dat);
        check("postreset_done_lat", 32'(dat), 32'(exp_cycles - 1));

        // start held high through done: back-to-back samples
        do_reset();
        add_sample(NF_A, -1, -1, 0, 1'b0, 0, 1'b1);
        add_sample(NF_A, -1, -1, 0, 1'b0, 0, 1'b0);
        add_idle(2);
        run_sched(1'b0, -1, "b2b", dat);
        check("b2b_done_lat", 32'(dat), 32'd41);
        check_perf(1'b0, "b2b");

        // single-fold configuration
        do_reset();
        add_sample(NF_B, -1, -1, 0, 1'b0, 0, 1'b0);
        add_idle(2);
        run_sched(1'b1, -1, "onefold", dat);
        check("onefold_done_lat", 32'(dat), 32'd6);
        check_perf(1'b1, "onefold");

        // randomized stalls and ack delays
        for (int r = 0; r < 4; r++) begin
            do_reset();
            add_sample(NF_A, -1, -1, 0, 1'b1, -1, 1'b0);
            add_idle(1);
            run_sched(1'b0, -1, $sformatf("rand%0d", r), dat);
            check($sformatf("rand%0d_done_lat", r), 32'(dat), 32'(exp_cycles - 1));
            check_perf(1'b0, $sformatf("rand%0d", r));
        end
        for (int r = 0; r < 2; r++) begin
            do_reset();
            add_sample(NF_B, -1, -1, 0, 1'b1, -1, 1'b0);
            add_idle(1);
            run_sched(1'b1, -1, $sformatf("rand1f%0d", r), dat);
            check($sformatf("rand1f%0d_done_lat", r), 32'(dat), 32'(exp_cycles - 1));
            check_perf(1'b1, $sformatf("rand1f%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
